// File: rtl/upc_watch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : upc_watch                                                       |
// | Brief    : Micro-PC checkpoint monitor: table-driven match, pass/fail,     |
// |            loop counting and microsequencer redirect requests.             |
// |            Optional LOOP mode and counters: `UPC_WATCH_LOOP_EN.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module upc_watch #(
    parameter int NCHAN = 32,
    parameter int PCW   = 12,
    parameter int CNTW  = 16,
    localparam int IDXW = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire,
    input  logic [PCW-1:0]   pc_x,
    input  logic [PCW-1:0]   pc_f,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic [2:0]       cfg_mode,
    input  logic [PCW-1:0]   cfg_from,
    input  logic [PCW-1:0]   cfg_to,
    input  logic [PCW-1:0]   cfg_target,
    input  logic [CNTW-1:0]  cfg_count,
    output logic             redir_valid,
    output logic [PCW-1:0]   redir_addr,
    input  logic             redir_ready,
    output logic             ev_valid,
    output logic [IDXW-1:0]  ev_idx,
    output logic [NCHAN-1:0] pass_mask,
    output logic             fail,
    output logic             done,
    output logic             overrun
);

    localparam logic [2:0] c_MODE_OFF  = 3'd0;
    localparam logic [2:0] c_MODE_JUMP = 3'd1;
    localparam logic [2:0] c_MODE_LOOP = 3'd2;
    localparam logic [2:0] c_MODE_FAIL = 3'd3;
    localparam logic [2:0] c_MODE_DONE = 3'd4;

    logic [2:0]       r_mode   [NCHAN];
    logic [PCW-1:0]   r_from   [NCHAN];
    logic [PCW-1:0]   r_to     [NCHAN];
    logic [PCW-1:0]   r_target [NCHAN];

    logic             r_redir_valid;
    logic [PCW-1:0]   r_redir_addr;
    logic             r_ev_valid;
    logic [IDXW-1:0]  r_ev_idx;
    logic [NCHAN-1:0] r_pass;
    logic             r_fail;
    logic             r_done;
    logic             r_overrun;

    logic [NCHAN-1:0] w_hit;
    logic             w_any;
    logic [IDXW-1:0]  w_win;
    logic             w_pending;
    logic             w_event;
    logic             w_pass;
    logic             w_load;
    logic [PCW-1:0]   w_load_addr;
    logic             w_set_fail;
    logic             w_set_done;
    logic             w_drop;

`ifdef UPC_WATCH_LOOP_EN
    logic [CNTW-1:0]  r_limit [NCHAN];
    logic [CNTW-1:0]  r_iter  [NCHAN];
    logic             w_iter_inc;
    logic             w_iter_clr;
    logic [CNTW:0]    w_iter_next;
`else
    logic             w_unused;
    assign w_unused = ^cfg_count;
`endif

    // Per-channel match; everything is frozen once the run has failed or completed.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (retire && !r_fail && !r_done) begin
                case (r_mode[i])
                    c_MODE_JUMP: w_hit[i] = (pc_x == r_from[i]) && (pc_f == r_to[i]);
`ifdef UPC_WATCH_LOOP_EN
                    c_MODE_LOOP: w_hit[i] = (pc_x == r_from[i]);
`endif
                    c_MODE_FAIL,
                    c_MODE_DONE: w_hit[i] = (pc_x == r_from[i]);
                    default:     w_hit[i] = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any = 1'b1;
                w_win = IDXW'(i);
            end
        end
    end

    // A redirect is still occupied only if it is not being accepted this cycle.
    always_comb begin
        w_pending   = r_redir_valid && !redir_ready;
        w_event     = 1'b0;
        w_pass      = 1'b0;
        w_load      = 1'b0;
        w_load_addr = r_from[w_win];
        w_set_fail  = 1'b0;
        w_set_done  = 1'b0;
        w_drop      = 1'b0;
`ifdef UPC_WATCH_LOOP_EN
        w_iter_inc  = 1'b0;
        w_iter_clr  = 1'b0;
        w_iter_next = {1'b0, r_iter[w_win]} + (CNTW+1)'(1);
`endif
        if (w_any) begin
            case (r_mode[w_win])
                c_MODE_JUMP: begin
                    if (w_pending) begin
                        w_drop = 1'b1;
                    end else begin
                        w_event     = 1'b1;
                        w_pass      = 1'b1;
                        w_load      = 1'b1;
                        w_load_addr = r_target[w_win];
                    end
                end
`ifdef UPC_WATCH_LOOP_EN
                c_MODE_LOOP: begin
                    if (w_iter_next < {1'b0, r_limit[w_win]}) begin
                        if (w_pending) begin
                            w_drop = 1'b1;
                        end else begin
                            w_load     = 1'b1;
                            w_iter_inc = 1'b1;
                        end
                    end else begin
                        w_event    = 1'b1;
                        w_pass     = 1'b1;
                        w_iter_clr = 1'b1;
                    end
                end
`endif
                c_MODE_FAIL: begin
                    w_set_fail = 1'b1;
                    w_event    = 1'b1;
                end
                c_MODE_DONE: begin
                    w_set_done = 1'b1;
                    w_event    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCHAN; i++) begin
                r_mode[i]   <= c_MODE_OFF;
                r_from[i]   <= '0;
                r_to[i]     <= '0;
                r_target[i] <= '0;
            end
        end else if (cfg_we) begin
            r_mode[cfg_idx]   <= cfg_mode;
            r_from[cfg_idx]   <= cfg_from;
            r_to[cfg_idx]     <= cfg_to;
            r_target[cfg_idx] <= cfg_target;
        end
    end

`ifdef UPC_WATCH_LOOP_EN
    // A table write lands after the match update, so it always clears the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCHAN; i++) begin
                r_limit[i] <= '0;
                r_iter[i]  <= '0;
            end
        end else begin
            if (w_iter_inc) r_iter[w_win] <= w_iter_next[CNTW-1:0];
            if (w_iter_clr) r_iter[w_win] <= '0;
            if (cfg_we) begin
                r_limit[cfg_idx] <= cfg_count;
                r_iter[cfg_idx]  <= '0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redir_valid <= 1'b0;
            r_redir_addr  <= '0;
            r_ev_valid    <= 1'b0;
            r_ev_idx      <= '0;
            r_pass        <= '0;
            r_fail        <= 1'b0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_ev_valid <= w_event;
            if (w_event) r_ev_idx <= w_win;
            if (w_load) begin
                r_redir_valid <= 1'b1;
                r_redir_addr  <= w_load_addr;
            end else if (redir_ready) begin
                r_redir_valid <= 1'b0;
            end
            if (w_pass) r_pass[w_win] <= 1'b1;
            if (cfg_we) r_pass[cfg_idx] <= 1'b0;
            if (w_set_fail) r_fail <= 1'b1;
            if (w_set_done) r_done <= 1'b1;
            if (w_drop) r_overrun <= 1'b1;
        end
    end

    assign redir_valid = r_redir_valid;
    assign redir_addr  = r_redir_addr;
    assign ev_valid    = r_ev_valid;
    assign ev_idx      = r_ev_idx;
    assign pass_mask   = r_pass;
    assign fail        = r_fail;
    assign done        = r_done;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_upc_watch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_upc_watch                                                    |
// | Brief    : Self-checking bench for upc_watch: vector table, directed       |
// |            corner sequences and randomized traffic against a model.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_upc_watch;

    localparam int NCHAN = 32;
    localparam int PCW   = 12;
    localparam int CNTW  = 16;
    localparam int IDXW  = 5;
`ifdef UPC_WATCH_LOOP_EN
    localparam bit c_LOOP_ON = 1'b1;
`else
    localparam bit c_LOOP_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             retire = 1'b0;
    logic [PCW-1:0]   pc_x = '0;
    logic [PCW-1:0]   pc_f = '0;
    logic             cfg_we = 1'b0;
    logic [IDXW-1:0]  cfg_idx = '0;
    logic [2:0]       cfg_mode = '0;
    logic [PCW-1:0]   cfg_from = '0;
    logic [PCW-1:0]   cfg_to = '0;
    logic [PCW-1:0]   cfg_target = '0;
    logic [CNTW-1:0]  cfg_count = '0;
    logic             redir_ready = 1'b0;
    logic             redir_valid;
    logic [PCW-1:0]   redir_addr;
    logic             ev_valid;
    logic [IDXW-1:0]  ev_idx;
    logic [NCHAN-1:0] pass_mask;
    logic             fail;
    logic             done;
    logic             overrun;

    int n_checks = 0;
    int n_fail   = 0;

    upc_watch #(.NCHAN(NCHAN), .PCW(PCW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .retire(retire), .pc_x(pc_x), .pc_f(pc_f),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mode(cfg_mode),
        .cfg_from(cfg_from), .cfg_to(cfg_to), .cfg_target(cfg_target),
        .cfg_count(cfg_count), .redir_valid(redir_valid), .redir_addr(redir_addr),
        .redir_ready(redir_ready), .ev_valid(ev_valid), .ev_idx(ev_idx),
        .pass_mask(pass_mask), .fail(fail), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        retire = 1'b0;
        cfg_we = 1'b0;
        redir_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg(input int idx, input int mode, input int from, input int to,
                       input int tgt, input int cnt);
        cfg_we = 1'b1;
        cfg_idx = IDXW'(idx);
        cfg_mode = 3'(mode);
        cfg_from = PCW'(from);
        cfg_to = PCW'(to);
        cfg_target = PCW'(tgt);
        cfg_count = CNTW'(cnt);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic ret(input int px, input int pf, input logic rdy);
        retire = 1'b1;
        pc_x = PCW'(px);
        pc_f = PCW'(pf);
        redir_ready = rdy;
        tick();
        retire = 1'b0;
    endtask

    // ---------------- reference model ----------------
    int m_mode [NCHAN];
    int m_from [NCHAN];
    int m_to   [NCHAN];
    int m_tgt  [NCHAN];
    int m_lim  [NCHAN];
    int m_iter [NCHAN];
    bit [NCHAN-1:0] m_pass;
    bit m_fail, m_done, m_ovr, m_rv, m_ev;
    int m_ra, m_evidx;

    task automatic model_reset();
        for (int i = 0; i < NCHAN; i++) begin
            m_mode[i] = 0; m_from[i] = 0; m_to[i] = 0;
            m_tgt[i] = 0; m_lim[i] = 0; m_iter[i] = 0;
        end
        m_pass = '0;
        {m_fail, m_done, m_ovr, m_rv, m_ev} = '0;
        m_ra = 0;
        m_evidx = 0;
    endtask

    // One clock of behaviour, evaluated from the currently driven inputs.
    task automatic model_tick();
        int  w;
        bit  busy;
        w = -1;
        busy = m_rv && !redir_ready;
        if (redir_ready) m_rv = 1'b0;
        m_ev = 1'b0;
        if (retire && !m_fail && !m_done) begin
            for (int i = 0; i < NCHAN; i++) begin
                bit h;
                h = 1'b0;
                if (m_mode[i] == 1) h = (int'(pc_x) == m_from[i]) && (int'(pc_f) == m_to[i]);
                if (m_mode[i] == 2) h = c_LOOP_ON && (int'(pc_x) == m_from[i]);
                if (m_mode[i] == 3 || m_mode[i] == 4) h = (int'(pc_x) == m_from[i]);
                if (h && w < 0) w = i;
            end
        end
        if (w >= 0) begin
            case (m_mode[w])
                1: if (busy) m_ovr = 1'b1;
                   else begin m_ev = 1'b1; m_pass[w] = 1'b1; m_rv = 1'b1; m_ra = m_tgt[w]; end
                2: if (m_iter[w] + 1 < m_lim[w]) begin
                       if (busy) m_ovr = 1'b1;
                       else begin m_rv = 1'b1; m_ra = m_from[w]; m_iter[w]++; end
                   end else begin
                       m_ev = 1'b1; m_pass[w] = 1'b1; m_iter[w] = 0;
                   end
                3: begin m_fail = 1'b1; m_ev = 1'b1; end
                4: begin m_done = 1'b1; m_ev = 1'b1; end
                default: ;
            endcase
            if (m_ev) m_evidx = w;
        end
        if (cfg_we) begin
            m_mode[cfg_idx] = int'(cfg_mode);
            m_from[cfg_idx] = int'(cfg_from);
            m_to[cfg_idx]   = int'(cfg_to);
            m_tgt[cfg_idx]  = int'(cfg_target);
            m_lim[cfg_idx]  = int'(cfg_count);
            m_iter[cfg_idx] = 0;
            m_pass[cfg_idx] = 1'b0;
        end
    endtask

    task automatic compare_model();
        chk("rnd redir_valid", 64'(redir_valid), 64'(m_rv));
        chk("rnd redir_addr",  64'(redir_addr),  64'(m_ra));
        chk("rnd ev_valid",    64'(ev_valid),    64'(m_ev));
        chk("rnd ev_idx",      64'(ev_idx),      64'(m_evidx));
        chk("rnd pass_mask",   64'(pass_mask),   64'(m_pass));
        chk("rnd fail",        64'(fail),        64'(m_fail));
        chk("rnd done",        64'(done),        64'(m_done));
        chk("rnd overrun",     64'(overrun),     64'(m_ovr));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic           retire;
        logic [PCW-1:0] px;
        logic [PCW-1:0] pf;
        logic           rdy;
        logic           rv;
        logic [PCW-1:0] ra;
        logic           ev;
        logic [IDXW-1:0] idx;
        logic           ovr;
    } vec_t;

    vec_t vt [14];

    initial begin
        int pool [4];
        pool = '{10, 20, 30, 40};

        // Two identical JUMP entries: the lower index must win every time.
        vt[0]  = '{1'b1, 12'd112, 12'd1085, 1'b0, 1'b1, 12'd226, 1'b1, 5'd2, 1'b0};
        vt[1]  = '{1'b0, 12'd0,   12'd0,    1'b0, 1'b1, 12'd226, 1'b0, 5'd2, 1'b0};
        vt[2]  = '{1'b0, 12'd0,   12'd0,    1'b0, 1'b1, 12'd226, 1'b0, 5'd2, 1'b0};
        vt[3]  = '{1'b0, 12'd0,   12'd0,    1'b0, 1'b1, 12'd226, 1'b0, 5'd2, 1'b0};
        vt[4]  = '{1'b0, 12'd0,   12'd0,    1'b1, 1'b0, 12'd226, 1'b0, 5'd2, 1'b0};
        vt[5]  = '{1'b1, 12'd112, 12'd1000, 1'b1, 1'b0, 12'd226, 1'b0, 5'd2, 1'b0};
        vt[6]  = '{1'b1, 12'd112, 12'd1085, 1'b1, 1'b1, 12'd226, 1'b1, 5'd2, 1'b0};
        vt[7]  = '{1'b0, 12'd0,   12'd0,    1'b1, 1'b0, 12'd226, 1'b0, 5'd2, 1'b0};
        vt[8]  = '{1'b1, 12'd112, 12'd1085, 1'b1, 1'b1, 12'd226, 1'b1, 5'd2, 1'b0};
        vt[9]  = '{1'b1, 12'd112, 12'd1085, 1'b1, 1'b1, 12'd226, 1'b1, 5'd2, 1'b0};
        vt[10] = '{1'b0, 12'd0,   12'd0,    1'b1, 1'b0, 12'd226, 1'b0, 5'd2, 1'b0};
        vt[11] = '{1'b1, 12'd112, 12'd1085, 1'b0, 1'b1, 12'd226, 1'b1, 5'd2, 1'b0};
        vt[12] = '{1'b1, 12'd112, 12'd1085, 1'b0, 1'b1, 12'd226, 1'b0, 5'd2, 1'b1};
        vt[13] = '{1'b0, 12'd0,   12'd0,    1'b1, 1'b0, 12'd226, 1'b0, 5'd2, 1'b1};

        #1;
        chk("reset redir_valid", 64'(redir_valid), 64'd0);
        chk("reset redir_addr",  64'(redir_addr),  64'd0);
        chk("reset ev_valid",    64'(ev_valid),    64'd0);
        chk("reset ev_idx",      64'(ev_idx),      64'd0);
        chk("reset pass_mask",   64'(pass_mask),   64'd0);
        chk("reset flags",       64'({fail, done, overrun}), 64'd0);
        tick();
        reset = 1'b0;

        cfg(5, 1, 112, 1085, 500, 0);
        cfg(2, 1, 112, 1085, 226, 0);
        for (int k = 0; k < 14; k++) begin
            retire = vt[k].retire;
            pc_x = vt[k].px;
            pc_f = vt[k].pf;
            redir_ready = vt[k].rdy;
            tick();
            chk($sformatf("vec%0d redir_valid", k), 64'(redir_valid), 64'(vt[k].rv));
            if (vt[k].rv) chk($sformatf("vec%0d redir_addr", k), 64'(redir_addr), 64'(vt[k].ra));
            chk($sformatf("vec%0d ev_valid", k), 64'(ev_valid), 64'(vt[k].ev));
            chk($sformatf("vec%0d ev_idx", k),   64'(ev_idx),   64'(vt[k].idx));
            chk($sformatf("vec%0d overrun", k),  64'(overrun),  64'(vt[k].ovr));
            chk($sformatf("vec%0d pass_mask", k), 64'(pass_mask), 64'h4);
        end
        retire = 1'b0;

        // Asynchronous reset while a redirect is pending.
        ret(112, 1085, 1'b0);
        chk("pre-reset redir_valid", 64'(redir_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset outputs",
            64'({redir_valid, ev_valid, fail, done, overrun}), 64'd0);
        chk("async reset addr/mask", 64'({redir_addr, pass_mask}), 64'd0);
        tick();
        reset = 1'b0;
        ret(112, 1085, 1'b1);
        chk("post-reset no redirect", 64'({redir_valid, ev_valid}), 64'd0);

        // FAIL then DONE: matching freezes once fail is set.
        cfg(0, 3, 869, 0, 0, 0);
        cfg(1, 4, 864, 0, 0, 0);
        ret(869, 0, 1'b1);
        chk("fail set", 64'({fail, ev_valid, ev_idx}), 64'({1'b1, 1'b1, 5'd0}));
        ret(864, 0, 1'b1);
        chk("done suppressed", 64'({done, ev_valid}), 64'd0);
        do_reset();
        cfg(1, 4, 864, 0, 0, 0);
        ret(864, 0, 1'b1);
        chk("done set", 64'({done, ev_valid, ev_idx}), 64'({1'b1, 1'b1, 5'd1}));
        do_reset();

        // LOOP count=4 with ready tied high.
        cfg(7, 2, 300, 0, 0, 4);
        redir_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            bool_loop: begin
                logic e_rv, e_ev;
                e_rv = c_LOOP_ON && ((r % 4) != 3);
                e_ev = c_LOOP_ON && ((r % 4) == 3);
                ret(300, 0, 1'b1);
                chk($sformatf("loop%0d redir_valid", r), 64'(redir_valid), 64'(e_rv));
                if (e_rv) chk($sformatf("loop%0d redir_addr", r), 64'(redir_addr), 64'd300);
                chk($sformatf("loop%0d ev", r), 64'({ev_valid, pass_mask[7]}),
                    64'({e_ev, c_LOOP_ON && (r >= 3)}));
            end
        end
        // Write to the channel matching in the same cycle: counter restarts from zero.
        ret(300, 0, 1'b1);
        retire = 1'b1; pc_x = 12'd300;
        cfg(7, 2, 300, 0, 0, 4);
        retire = 1'b0;
        chk("loop cfg collision redirect", 64'(redir_valid), 64'(c_LOOP_ON));
        chk("loop cfg clears pass", 64'(pass_mask[7]), 64'd0);
        for (int r = 0; r < 3; r++) ret(300, 0, 1'b1);
        chk("loop restarted count", 64'({ev_valid, redir_valid}), 64'({1'b0, c_LOOP_ON}));
        ret(300, 0, 1'b1);
        chk("loop restarted report", 64'(ev_valid), 64'(c_LOOP_ON));
        cfg(8, 2, 310, 0, 0, 0);
        ret(310, 0, 1'b1);
        chk("loop count0 reports", 64'({ev_valid, redir_valid}), 64'({c_LOOP_ON, 1'b0}));

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                model_reset();
            end else begin
                int sel;
                retire = 1'($urandom_range(0, 1));
                pc_x = PCW'(pool[$urandom_range(0, 3)]);
                pc_f = PCW'(pool[$urandom_range(0, 3)]);
                redir_ready = ($urandom_range(0, 3) != 0);
                cfg_we = ($urandom_range(0, 5) == 0);
                cfg_idx = IDXW'($urandom_range(0, 7));
                sel = $urandom_range(0, 19);
                cfg_mode = (sel < 8) ? 3'd1 : (sel < 16) ? 3'd2 :
                           (sel == 16) ? 3'd3 : (sel == 17) ? 3'd4 : 3'd0;
                cfg_from = PCW'(pool[$urandom_range(0, 3)]);
                cfg_to = PCW'(pool[$urandom_range(0, 3)]);
                cfg_target = PCW'($urandom_range(0, 4095));
                cfg_count = CNTW'($urandom_range(0, 4));
                model_tick();
                tick();
                compare_model();
            end
        end
        retire = 1'b0;
        cfg_we = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
